// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multicycle sequencer for the 8-bit MIPS core.
// Fetches 16-bit instructions over a req/ack handshake, holds the IR and
// walks IF -> ID -> RR -> EX -> (RWB) -> IF, with IDLE and HLT side states.
// Optional single-step support is compiled in with CPU_CTRL_STEP_EN.
module cpu_ctrl #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  input  logic            cmp_flag,
`ifdef CPU_CTRL_STEP_EN
  input  logic            step_mode,
  input  logic            step,
`endif
  output logic [2:0]      current_state,
  output logic [3:0]      OPCODE,
  output logic [3:0]      RD,
  output logic [3:0]      RA,
  output logic [3:0]      RB,
  output logic            rf_we,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_RR   = 3'b010,
    S_EX   = 3'b011,
    S_RWB  = 3'b100,
    S_HLT  = 3'b101,
    S_IDLE = 3'b110
  } state_t;

  // Control opcodes shared with the ALU opcode map; everything else writes back.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_CMPJ = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;

  logic            step_hold;
  logic            step_go;
  logic [3:0]      op;
  logic            writes_rf;
  logic [PC_W-1:0] jump_target;
  state_t          retire_state;

`ifdef CPU_CTRL_STEP_EN
  assign step_hold = step_mode;
  assign step_go   = step;
`else
  assign step_hold = 1'b0;
  assign step_go   = 1'b0;
`endif

  assign op          = ir_q[15:12];
  assign writes_rf   = !((op == OP_JMP) || (op == OP_CMPJ) ||
                         (op == OP_NOP) || (op == OP_HALT));
  assign jump_target = PC_W'(ir_q[7:0]);
  // In step mode each retired instruction parks the core in IDLE.
  assign retire_state = step_hold ? S_IDLE : S_IF;

  // Next-state, next-pc and IR load logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (step_hold ? step_go : run) state_d = S_IF;
      end
      S_IF: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_ID;
        end
      end
      S_ID: begin
        state_d = (op == OP_HALT) ? S_HLT : S_RR;
      end
      S_RR: begin
        state_d = S_EX;
      end
      S_EX: begin
        case (op)
          OP_JMP: begin
            pc_d    = jump_target;
            state_d = retire_state;
          end
          OP_CMPJ: begin
            if (cmp_flag) pc_d = jump_target;
            state_d = retire_state;
          end
          OP_NOP:  state_d = retire_state;
          default: state_d = S_RWB;
        endcase
      end
      S_RWB: begin
        state_d = retire_state;
      end
      S_HLT: begin
        state_d = S_HLT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, pc and IR registers; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign current_state = state_q;
  assign pc            = pc_q;
  assign imem_addr     = pc_q;
  assign OPCODE        = ir_q[15:12];
  assign RD            = ir_q[11:8];
  assign RA            = ir_q[7:4];
  assign RB            = ir_q[3:0];
  assign imem_req      = (state_q == S_IF);
  assign rf_we         = (state_q == S_RWB) && writes_rf;
  assign halted        = (state_q == S_HLT);

endmodule

// File: tb/tb_cpu_ctrl.sv
// Testbench for cpu_ctrl: directed scenarios plus a randomized run checked
// against an instruction-level reference model.
module tb_cpu_ctrl;

  localparam logic [2:0] ST_IF = 3'b000, ST_ID = 3'b001, ST_RR = 3'b010,
                         ST_EX = 3'b011, ST_RWB = 3'b100, ST_HLT = 3'b101,
                         ST_IDLE = 3'b110;
  localparam logic [3:0] OP_NOP = 4'h0, OP_JMP = 4'hA, OP_CMPJ = 4'hB,
                         OP_HALT = 4'hF;

  logic        clk = 1'b0;
  logic        reset, run, imem_ack, cmp_flag;
  logic [15:0] imem_data;
  logic        imem_req, rf_we, halted;
  logic [7:0]  imem_addr, pc;
  logic [2:0]  current_state;
  logic [3:0]  OPCODE, RD, RA, RB;
  logic [15:0] ir_obs;
`ifdef CPU_CTRL_STEP_EN
  logic        step_mode, step;
`endif

  logic [15:0] mem [256];
  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  st;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic        c;
  } exp_t;
  exp_t q[$];

  cpu_ctrl #(.PC_W(8)) dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .cmp_flag(cmp_flag),
`ifdef CPU_CTRL_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .current_state(current_state), .OPCODE(OPCODE), .RD(RD), .RA(RA), .RB(RB),
    .rf_we(rf_we), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;
  always_comb imem_data = mem[imem_addr];
  assign ir_obs = {OPCODE, RD, RA, RB};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mem;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1; run = 1'b0; imem_ack = 1'b0; cmp_flag = 1'b0;
`ifdef CPU_CTRL_STEP_EN
    step_mode = 1'b0; step = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    clear_mem();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (current_state !== ST_IDLE) begin
        n_fail++; $display("FAIL reset_state: got %b want %b", current_state, ST_IDLE);
      end
      n_cmp++;
      if (pc !== 8'h00 || ir_obs !== 16'h0000) begin
        n_fail++; $display("FAIL reset_pc_ir: got pc=%h ir=%h want 00/0000", pc, ir_obs);
      end
      n_cmp++;
      if ({imem_req, rf_we, halted} !== 3'b000) begin
        n_fail++; $display("FAIL reset_outs: got req/we/halt=%b want 000", {imem_req, rf_we, halted});
      end
    end
  endtask

  task automatic test_alu_zero_wait;
    logic [2:0] es [6] = '{ST_IF, ST_ID, ST_RR, ST_EX, ST_RWB, ST_IF};
    clear_mem();
    mem[0] = 16'h1234;
    do_reset();
    run = 1'b1; imem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (current_state !== es[i]) begin
        n_fail++; $display("FAIL alu_state[%0d]: got %b want %b", i, current_state, es[i]);
      end
      n_cmp++;
      if (rf_we !== (i == 4)) begin
        n_fail++; $display("FAIL alu_rf_we[%0d]: got %b want %b", i, rf_we, (i == 4));
      end
      n_cmp++;
      if (pc !== ((i == 0) ? 8'h00 : 8'h01)) begin
        n_fail++; $display("FAIL alu_pc[%0d]: got %h want %h", i, pc, (i == 0) ? 8'h00 : 8'h01);
      end
      if (i == 1) begin
        n_cmp++;
        if (ir_obs !== 16'h1234) begin
          n_fail++; $display("FAIL alu_ir: got %h want 1234", ir_obs);
        end
      end
    end
    run = 1'b0; imem_ack = 1'b0;
  endtask

  task automatic test_ack_wait;
    clear_mem();
    mem[0] = 16'h2567;
    do_reset();
    run = 1'b1; imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (current_state !== ST_IF || imem_req !== 1'b1 || imem_addr !== 8'h00) begin
        n_fail++; $display("FAIL wait_if[%0d]: got st=%b req=%b addr=%h want 000/1/00",
                           i, current_state, imem_req, imem_addr);
      end
      n_cmp++;
      if (pc !== 8'h00 || ir_obs !== 16'h0000) begin
        n_fail++; $display("FAIL wait_hold[%0d]: got pc=%h ir=%h want 00/0000", i, pc, ir_obs);
      end
      if (i == 3) imem_ack = 1'b1;
    end
    @(negedge clk);
    imem_ack = 1'b0;
    n_cmp++;
    if (current_state !== ST_ID || pc !== 8'h01 || ir_obs !== 16'h2567) begin
      n_fail++; $display("FAIL wait_id: got st=%b pc=%h ir=%h want 001/01/2567",
                         current_state, pc, ir_obs);
    end
    run = 1'b0;
  endtask

  task automatic test_jmp;
    logic [2:0] es [5] = '{ST_IF, ST_ID, ST_RR, ST_EX, ST_IF};
    clear_mem();
    mem[0] = {OP_JMP, 4'h0, 8'h40};
    do_reset();
    run = 1'b1; imem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (current_state !== es[i]) begin
        n_fail++; $display("FAIL jmp_state[%0d]: got %b want %b", i, current_state, es[i]);
      end
    end
    n_cmp++;
    if (pc !== 8'h40 || imem_addr !== 8'h40) begin
      n_fail++; $display("FAIL jmp_target: got pc=%h addr=%h want 40/40", pc, imem_addr);
    end
    run = 1'b0; imem_ack = 1'b0;
  endtask

  task automatic test_cmpj(input logic c);
    logic [7:0] want;
    clear_mem();
    mem[0] = {OP_CMPJ, 4'h0, 8'h10};
    do_reset();
    run = 1'b1; imem_ack = 1'b1; cmp_flag = c;
    repeat (5) @(negedge clk);
    want = c ? 8'h10 : 8'h01;
    n_cmp++;
    if (current_state !== ST_IF || pc !== want) begin
      n_fail++; $display("FAIL cmpj_c%0d: got st=%b pc=%h want 000/%h", c, current_state, pc, want);
    end
    run = 1'b0; imem_ack = 1'b0; cmp_flag = 1'b0;
  endtask

  task automatic test_pc_wrap;
    clear_mem();
    mem[0] = {OP_JMP, 4'h0, 8'hFF};
    mem[255] = 16'h0000;
    do_reset();
    run = 1'b1; imem_ack = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (current_state !== ST_IF || pc !== 8'hFF) begin
      n_fail++; $display("FAIL wrap_pre: got st=%b pc=%h want 000/ff", current_state, pc);
    end
    @(negedge clk);
    n_cmp++;
    if (current_state !== ST_ID || pc !== 8'h00) begin
      n_fail++; $display("FAIL wrap_post: got st=%b pc=%h want 001/00", current_state, pc);
    end
    run = 1'b0; imem_ack = 1'b0;
  endtask

  task automatic test_halt;
    clear_mem();
    mem[0] = {OP_HALT, 12'h000};
    do_reset();
    run = 1'b1; imem_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (current_state !== ST_HLT || halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_enter: got st=%b halted=%b want 101/1", current_state, halted);
    end
    for (int i = 0; i < 20; i++) begin
      run = i[0]; imem_ack = 1'($urandom_range(0, 1)); cmp_flag = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_cmp++;
      if (current_state !== ST_HLT || halted !== 1'b1 || pc !== 8'h01 || imem_req !== 1'b0) begin
        n_fail++; $display("FAIL halt_hold[%0d]: got st=%b halted=%b pc=%h req=%b want 101/1/01/0",
                           i, current_state, halted, pc, imem_req);
      end
    end
    run = 1'b0; imem_ack = 1'b0; cmp_flag = 1'b0;
  endtask

  task automatic test_reset_in_if_ack;
    clear_mem();
    mem[1] = 16'h1234;
    do_reset();
    run = 1'b1; imem_ack = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (current_state !== ST_IF || pc !== 8'h01) begin
      n_fail++; $display("FAIL rst_if_pre: got st=%b pc=%h want 000/01", current_state, pc);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (current_state !== ST_IDLE || pc !== 8'h00 || ir_obs !== 16'h0000 || rf_we !== 1'b0) begin
      n_fail++; $display("FAIL rst_if: got st=%b pc=%h ir=%h we=%b want 110/00/0000/0",
                         current_state, pc, ir_obs, rf_we);
    end
    reset = 1'b0; run = 1'b0; imem_ack = 1'b0;
  endtask

  task automatic test_reset_in_rwb;
    clear_mem();
    mem[0] = 16'h1234;
    do_reset();
    run = 1'b1; imem_ack = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (current_state !== ST_RWB || rf_we !== 1'b1) begin
      n_fail++; $display("FAIL rst_rwb_pre: got st=%b we=%b want 100/1", current_state, rf_we);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (current_state !== ST_IDLE || pc !== 8'h00 || ir_obs !== 16'h0000 || rf_we !== 1'b0) begin
      n_fail++; $display("FAIL rst_rwb: got st=%b pc=%h ir=%h we=%b want 110/00/0000/0",
                         current_state, pc, ir_obs, rf_we);
    end
    reset = 1'b0; run = 1'b0; imem_ack = 1'b0;
  endtask

`ifdef CPU_CTRL_STEP_EN
  task automatic test_step;
    int cyc;
    clear_mem();
    mem[0] = 16'h1234;
    mem[2] = 16'h3456;
    do_reset();
    step_mode = 1'b1; run = 1'b1; step = 1'b0; imem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (current_state !== ST_IDLE) begin
        n_fail++; $display("FAIL step_idle_run: got %b want %b", current_state, ST_IDLE);
      end
    end
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      cyc = 0;
      while (current_state !== ST_IDLE && cyc < 12) begin
        @(negedge clk);
        cyc++;
      end
      n_cmp++;
      if (current_state !== ST_IDLE || cyc !== ((k == 1) ? 4 : 5) || pc !== 8'(k + 1)) begin
        n_fail++; $display("FAIL step_retire[%0d]: got st=%b cycles=%0d pc=%h want 110/%0d/%h",
                           k, current_state, cyc, pc, (k == 1) ? 4 : 5, 8'(k + 1));
      end
      repeat (2) begin
        @(negedge clk);
        n_cmp++;
        if (current_state !== ST_IDLE) begin
          n_fail++; $display("FAIL step_park[%0d]: got %b want %b", k, current_state, ST_IDLE);
        end
      end
    end
    step_mode = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (current_state !== ST_IF || pc !== 8'h04) begin
      n_fail++; $display("FAIL step_off: got st=%b pc=%h want 000/04", current_state, pc);
    end
    run = 1'b0; imem_ack = 1'b0;
  endtask
`endif

  // Instruction-level model: each fetched word expands into the cycles it
  // will occupy; with the queue empty the core is expected to be fetching.
  task automatic test_random;
    exp_t        e;
    logic [15:0] w;
    logic [7:0]  mpc, nxt;
    logic [15:0] mir;
    logic        c;
    logic [3:0]  o;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if (w[15:12] == OP_HALT) w[15:12] = 4'h1;
      mem[i] = w;
    end
    q.delete();
    mpc = 8'h00; mir = 16'h0000;
    do_reset();
    run = 1'b1;
    for (int cycle = 0; cycle < 600; cycle++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        e.st = ST_IF; e.pc = mpc; e.ir = mir; e.c = 1'b0;
      end else begin
        e = q.pop_front();
      end
      n_cmp++;
      if (current_state !== e.st) begin
        n_fail++; $display("FAIL rnd_state[%0d]: got %b want %b", cycle, current_state, e.st);
      end
      n_cmp++;
      if (pc !== e.pc || imem_addr !== e.pc) begin
        n_fail++; $display("FAIL rnd_pc[%0d]: got pc=%h addr=%h want %h", cycle, pc, imem_addr, e.pc);
      end
      n_cmp++;
      if (ir_obs !== e.ir) begin
        n_fail++; $display("FAIL rnd_ir[%0d]: got %h want %h", cycle, ir_obs, e.ir);
      end
      n_cmp++;
      if ({imem_req, rf_we, halted} !== {e.st == ST_IF, e.st == ST_RWB, 1'b0}) begin
        n_fail++; $display("FAIL rnd_outs[%0d]: got req/we/halt=%b want %b", cycle,
                           {imem_req, rf_we, halted}, {e.st == ST_IF, e.st == ST_RWB, 1'b0});
      end
      imem_ack = ($urandom_range(0, 9) < 6);
      run      = 1'($urandom_range(0, 1));
      cmp_flag = (e.st == ST_EX) ? e.c : 1'($urandom_range(0, 1));
      if (e.st == ST_IF && imem_ack) begin
        w   = mem[mpc];
        o   = w[15:12];
        nxt = mpc + 8'd1;
        c   = 1'($urandom_range(0, 1));
        q.push_back('{ST_ID, nxt, w, 1'b0});
        q.push_back('{ST_RR, nxt, w, 1'b0});
        q.push_back('{ST_EX, nxt, w, c});
        if (o != OP_JMP && o != OP_CMPJ && o != OP_NOP) q.push_back('{ST_RWB, nxt, w, 1'b0});
        if (o == OP_JMP || (o == OP_CMPJ && c)) mpc = w[7:0];
        else mpc = nxt;
        mir = w;
      end
    end
    run = 1'b0; imem_ack = 1'b0; cmp_flag = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; imem_ack = 1'b0; cmp_flag = 1'b0;
`ifdef CPU_CTRL_STEP_EN
    step_mode = 1'b0; step = 1'b0;
`endif
    clear_mem();
    test_reset();
    test_alu_zero_wait();
    test_ack_wait();
    test_jmp();
    test_cmpj(1'b0);
    test_cmpj(1'b1);
    test_pc_wrap();
    test_halt();
    test_reset_in_if_ack();
    test_reset_in_rwb();
`ifdef CPU_CTRL_STEP_EN
    test_step();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
